tlb_refill_arbiter: RTL and testbench

Shares the single lookup port of the unified L2 TLB between the L1 I-TLB and L1 D-TLB refill engines. It accepts refill requests (VPN2), grants one requester at a time under round-robin priority, drives the L2 lookup, registers the result and returns it to the granted requester as a one-cycle response pulse. It sits between the two L1 TLBs and the L2 TLB. It stalls lookups while a TLB write is in progress and re-runs any lookup that a TLB fence overlaps.

---
 rtl/tlb_refill_arbiter_pkg.sv | 22 ++
 rtl/tlb_refill_arbiter_rr_arb2.sv | 52 +++++
 rtl/tlb_refill_arbiter.sv | 134 +++++++++++++
 tb/tb_tlb_refill_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tlb_refill_arbiter_pkg.sv
// Shared definitions for the L2 TLB refill arbiter: the TLB entry layout
// and the requester IDs used for ownership and round-robin bookkeeping.
package tlb_refill_arbiter_pkg;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] PFN0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] PFN1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry;

    localparam logic REQ_ITLB = 1'b0;
    localparam logic REQ_DTLB = 1'b1;

endpackage

// File: rtl/tlb_refill_arbiter_rr_arb2.sv
// Two-way grant selection between the I-TLB and D-TLB refill requests.
// Default build: round-robin, with the pointer moved on i_advance to favour
// the side that did not own the finished grant.
// With TLB_ARB_DTLB_PRIO_EN defined the pointer is removed and the D-TLB
// always wins a tie.
module rr_arb2
    import tlb_refill_arbiter_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_itlb,
    input  logic i_req_dtlb,
    input  logic i_advance,
    input  logic i_owner,
    output logic o_grant_valid,
    output logic o_grant_id
);

    assign o_grant_valid = i_req_itlb | i_req_dtlb;

`ifdef TLB_ARB_DTLB_PRIO_EN

    // Fixed priority: the D-TLB wins whenever it is requesting.
    always_comb begin
        o_grant_id = i_req_dtlb ? REQ_DTLB : REQ_ITLB;
    end

`else

    logic r_ptr;

    // Pointer flips to the non-owner once the owner's response goes out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= REQ_DTLB;
        end else if (i_advance) begin
            r_ptr <= ~i_owner;
        end
    end

    // A tie goes to the pointer side; a lone request always wins.
    always_comb begin
        if (i_req_itlb && i_req_dtlb) begin
            o_grant_id = r_ptr;
        end else begin
            o_grant_id = i_req_dtlb ? REQ_DTLB : REQ_ITLB;
        end
    end

`endif

endmodule

// File: rtl/tlb_refill_arbiter.sv
// Shares the single L2 TLB lookup port between the I-TLB and D-TLB refill
// engines. One grant at a time, a registered L2 result, and a one-cycle
// response pulse to the owner. Lookups stall while a TLB write is in
// progress and are re-run whenever a TLB fence overlaps them.
// Optional feature macro: TLB_ARB_DTLB_PRIO_EN (D-TLB fixed priority).
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for a request; grants when no TLB write is active
// ST_LOOKUP | driving the L2 lookup; repeats while tlbw_busy/fence_tlb
// ST_RESP   | pulsing the owner's resp_valid with the captured result
module tlb_refill_arbiter
    import tlb_refill_arbiter_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_itlb_req,
    input  logic [31:13] i_itlb_vpn2,
    output logic        o_itlb_resp_valid,
    input  logic        i_dtlb_req,
    input  logic [31:13] i_dtlb_vpn2,
    output logic        o_dtlb_resp_valid,
    output logic        o_resp_found,
    output tlb_entry    o_resp_entry,
    output logic        o_l2_lookup_valid,
    output logic [31:13] o_l2_vpn2,
    input  logic        i_l2_found,
    input  tlb_entry    i_l2_entry,
    input  logic        i_tlbw_busy,
    input  logic        i_fence_tlb,
    output logic        o_arb_busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_owner;
    logic [31:13] r_vpn2;
    logic         r_found;
    tlb_entry     r_entry;

    logic w_grant_valid;
    logic w_grant_id;
    logic w_load;
    logic w_capture;
    logic w_advance;

    rr_arb2 u_rr_arb2 (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_itlb    (i_itlb_req),
        .i_req_dtlb    (i_dtlb_req),
        .i_advance     (w_advance),
        .i_owner       (r_owner),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state strobes/outputs.
    always_comb begin
        w_state_nxt       = r_state;
        w_load            = 1'b0;
        w_capture         = 1'b0;
        w_advance         = 1'b0;
        o_l2_lookup_valid = 1'b0;
        o_itlb_resp_valid = 1'b0;
        o_dtlb_resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid && !i_tlbw_busy) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                o_l2_lookup_valid = 1'b1;
                // A write or fence makes this cycle's L2 answer stale.
                if (!(i_tlbw_busy || i_fence_tlb)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                // The result is already registered, so a fence here is moot.
                w_advance         = 1'b1;
                o_itlb_resp_valid = (r_owner == REQ_ITLB);
                o_dtlb_resp_valid = (r_owner == REQ_DTLB);
                w_state_nxt       = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant ownership/VPN2 latch and L2 result capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_owner <= REQ_ITLB;
            r_vpn2  <= '0;
            r_found <= 1'b0;
            r_entry <= '0;
        end else begin
            if (w_load) begin
                r_owner <= w_grant_id;
                r_vpn2  <= (w_grant_id == REQ_DTLB) ? i_dtlb_vpn2 : i_itlb_vpn2;
            end
            if (w_capture) begin
                r_found <= i_l2_found;
                r_entry <= i_l2_entry;
            end
        end
    end

    assign o_l2_vpn2    = o_l2_lookup_valid ? r_vpn2 : '0;
    assign o_resp_found = r_found;
    assign o_resp_entry = r_entry;
    assign o_arb_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tlb_refill_arbiter.sv
// Directed bench for tlb_refill_arbiter. Inputs change and outputs are
// sampled 1 ns after each rising edge. Expected values are hand-derived.
module tb_tlb_refill_arbiter;
    import tlb_refill_arbiter_pkg::*;

    logic         clk;
    logic         rst;
    logic         itlb_req;
    logic [31:13] itlb_vpn2;
    logic         itlb_resp_valid;
    logic         dtlb_req;
    logic [31:13] dtlb_vpn2;
    logic         dtlb_resp_valid;
    logic         resp_found;
    tlb_entry     resp_entry;
    logic         l2_lookup_valid;
    logic [31:13] l2_vpn2;
    logic         l2_found;
    tlb_entry     l2_entry;
    logic         tlbw_busy;
    logic         fence_tlb;
    logic         arb_busy;

    int n_chk;
    int n_bad;

`ifdef TLB_ARB_DTLB_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    tlb_refill_arbiter dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_itlb_req        (itlb_req),
        .i_itlb_vpn2       (itlb_vpn2),
        .o_itlb_resp_valid (itlb_resp_valid),
        .i_dtlb_req        (dtlb_req),
        .i_dtlb_vpn2       (dtlb_vpn2),
        .o_dtlb_resp_valid (dtlb_resp_valid),
        .o_resp_found      (resp_found),
        .o_resp_entry      (resp_entry),
        .o_l2_lookup_valid (l2_lookup_valid),
        .o_l2_vpn2         (l2_vpn2),
        .i_l2_found        (l2_found),
        .i_l2_entry        (l2_entry),
        .i_tlbw_busy       (tlbw_busy),
        .i_fence_tlb       (fence_tlb),
        .o_arb_busy        (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Called in the IDLE slot where the grant is expected; returns in the
    // IDLE slot after the response pulse, with the owner's request dropped.
    task automatic serve(input string tag, input bit is_d, input logic [18:0] vpn,
                         input bit found, input logic [19:0] pfn);
        tick();
        chk({tag, ".lkv"}, 80'(l2_lookup_valid), 80'(1));
        chk({tag, ".vpn"}, 80'(l2_vpn2), 80'(vpn));
        chk({tag, ".early"}, 80'({itlb_resp_valid, dtlb_resp_valid}), 80'(0));
        tick();
        chk({tag, ".iresp"}, 80'(itlb_resp_valid), 80'(!is_d));
        chk({tag, ".dresp"}, 80'(dtlb_resp_valid), 80'(is_d));
        chk({tag, ".found"}, 80'(resp_found), 80'(found));
        chk({tag, ".pfn0"}, 80'(resp_entry.PFN0), 80'(pfn));
        if (is_d) dtlb_req = 1'b0;
        else      itlb_req = 1'b0;
        tick();
        chk({tag, ".pulse1"}, 80'({itlb_resp_valid, dtlb_resp_valid}), 80'(0));
        chk({tag, ".idle"}, 80'(arb_busy), 80'(0));
    endtask

    initial begin
        n_chk     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        itlb_req  = 1'b0;
        dtlb_req  = 1'b0;
        itlb_vpn2 = '0;
        dtlb_vpn2 = '0;
        l2_found  = 1'b0;
        l2_entry  = '0;
        tlbw_busy = 1'b0;
        fence_tlb = 1'b0;
        do_reset();

        chk("rst.resp", 80'({itlb_resp_valid, dtlb_resp_valid}), 80'(0));
        chk("rst.found", 80'(resp_found), 80'(0));
        chk("rst.entry", 80'(resp_entry), 80'(0));
        chk("rst.lkv", 80'(l2_lookup_valid), 80'(0));
        chk("rst.vpn", 80'(l2_vpn2), 80'(0));
        chk("rst.busy", 80'(arb_busy), 80'(0));

        // Single D-TLB hit.
        dtlb_req      = 1'b1;
        dtlb_vpn2     = 19'h00400;
        l2_found      = 1'b1;
        l2_entry.PFN0 = 20'h12345;
        serve("d_hit", 1'b1, 19'h00400, 1'b1, 20'h12345);
        chk("d_hit.hold", 80'(resp_entry.PFN0), 80'(20'h12345));

        // Tie after reset: D first; I still waiting when D re-requests.
        do_reset();
        l2_found  = 1'b0;
        l2_entry  = '0;
        itlb_req  = 1'b1;
        itlb_vpn2 = 19'h11111;
        dtlb_req  = 1'b1;
        dtlb_vpn2 = 19'h22222;
        serve("pair1.d", 1'b1, 19'h22222, 1'b0, 20'h0);
        dtlb_req  = 1'b1;
        dtlb_vpn2 = 19'h33333;
        if (FIXED_PRIO) begin
            serve("pair2.d", 1'b1, 19'h33333, 1'b0, 20'h0);
            serve("pair2.i", 1'b0, 19'h11111, 1'b0, 20'h0);
        end else begin
            serve("pair2.i", 1'b0, 19'h11111, 1'b0, 20'h0);
            serve("pair2.d", 1'b1, 19'h33333, 1'b0, 20'h0);
        end

        // Fence in LOOKUP: L2 goes miss -> hit, lookup repeated once.
        do_reset();
        itlb_req  = 1'b1;
        itlb_vpn2 = 19'h0ABCD;
        l2_found  = 1'b0;
        l2_entry  = '0;
        tick();
        chk("fence.lkv0", 80'(l2_lookup_valid), 80'(1));
        fence_tlb = 1'b1;
        tick();
        fence_tlb     = 1'b0;
        l2_found      = 1'b1;
        l2_entry.PFN0 = 20'h0F00D;
        chk("fence.lkv1", 80'(l2_lookup_valid), 80'(1));
        chk("fence.noresp", 80'(itlb_resp_valid), 80'(0));
        tick();
        chk("fence.resp", 80'(itlb_resp_valid), 80'(1));
        chk("fence.found", 80'(resp_found), 80'(1));
        chk("fence.pfn0", 80'(resp_entry.PFN0), 80'(20'h0F00D));
        itlb_req  = 1'b0;
        fence_tlb = 1'b1;
        tick();
        fence_tlb = 1'b0;
        chk("fence.done", 80'({itlb_resp_valid, arb_busy}), 80'(0));

        // tlbw_busy held 3 cycles in IDLE blocks the grant.
        do_reset();
        l2_found  = 1'b0;
        l2_entry  = '0;
        itlb_req  = 1'b1;
        itlb_vpn2 = 19'h05555;
        tlbw_busy = 1'b1;
        tick();
        chk("tlbw.c1", 80'(arb_busy), 80'(0));
        tick();
        chk("tlbw.c2", 80'(arb_busy), 80'(0));
        tick();
        tlbw_busy = 1'b0;
        chk("tlbw.c3", 80'(arb_busy), 80'(0));
        serve("tlbw.i", 1'b0, 19'h05555, 1'b0, 20'h0);

        // Reset in LOOKUP discards the grant; prior result is cleared too.
        l2_found      = 1'b1;
        l2_entry.PFN0 = 20'hABCDE;
        itlb_req      = 1'b1;
        itlb_vpn2     = 19'h00777;
        serve("pre_rst", 1'b0, 19'h00777, 1'b1, 20'hABCDE);
        dtlb_req  = 1'b1;
        dtlb_vpn2 = 19'h00999;
        tick();
        chk("mid.lkv", 80'(l2_lookup_valid), 80'(1));
        rst      = 1'b1;
        dtlb_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("mid.busy", 80'(arb_busy), 80'(0));
        chk("mid.lkv0", 80'(l2_lookup_valid), 80'(0));
        chk("mid.vpn", 80'(l2_vpn2), 80'(0));
        chk("mid.found", 80'(resp_found), 80'(0));
        chk("mid.entry", 80'(resp_entry), 80'(0));
        chk("mid.resp", 80'({itlb_resp_valid, dtlb_resp_valid}), 80'(0));
        tick();
        chk("mid.resp2", 80'({itlb_resp_valid, dtlb_resp_valid, arb_busy}), 80'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
